// File: rtl/issue_scoreboard.sv
// Issue scoreboard: holds one decoded instruction, tracks in-flight register
// writes per register and blocks issue on RAW/WAW hazards until writeback.
module issue_scoreboard #(
  parameter int REGNO     = 8,
  parameter int REGNO_LOG = 3,
  parameter int PEND_W    = 2,
  parameter int PAYLOAD_W = 48
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_submit,
  output logic                 o_ready,
  input  logic [REGNO_LOG-1:0] i_l_reg_sel,
  input  logic [REGNO_LOG-1:0] i_r_reg_sel,
  input  logic [1:0]           i_used_operands,
  input  logic [REGNO-1:0]     i_rf_ie,
  input  logic [PAYLOAD_W-1:0] i_payload,
  input  logic                 i_next_ready,
  output logic                 o_submit,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic [REGNO-1:0]     o_rf_ie,
  input  logic                 i_wb_valid,
  input  logic [REGNO-1:0]     i_wb_rf_ie,
  input  logic                 i_flush,
  output logic [15:0]          o_stall_cycles,
  output logic                 o_busy
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  // Index of the set bit of a one-hot register enable (0 when none set).
  function automatic logic [REGNO_LOG-1:0] onehot_idx(input logic [REGNO-1:0] oh);
    logic [REGNO_LOG-1:0] idx;
    idx = {REGNO_LOG{1'b0}};
    for (int k = 0; k < REGNO; k++) begin
      if (oh[k]) begin
        idx = REGNO_LOG'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic                 buf_valid_r;
  logic [REGNO_LOG-1:0] buf_l_r;
  logic [REGNO_LOG-1:0] buf_r_r;
  logic [1:0]           buf_used_r;
  logic [REGNO-1:0]     buf_rf_ie_r;
  logic [PAYLOAD_W-1:0] buf_payload_r;
  logic [PEND_W-1:0]    pend_r [REGNO];

  logic [PEND_W-1:0]    pend_next_s [REGNO];
  logic [REGNO_LOG-1:0] dst_s;
  logic                 hazard_s;
  logic                 issue_now_s;
  logic                 accept_s;
  logic                 busy_next_s;
  logic                 underflow_s;

  assign dst_s       = onehot_idx(buf_rf_ie_r);
  assign hazard_s    = (buf_used_r[0] && (pend_r[buf_l_r] != {PEND_W{1'b0}})) ||
                       (buf_used_r[1] && (pend_r[buf_r_r] != {PEND_W{1'b0}})) ||
                       ((buf_rf_ie_r != {REGNO{1'b0}}) && (pend_r[dst_s] == PEND_MAX));
  assign issue_now_s = buf_valid_r && !hazard_s && i_next_ready && !i_flush;
  assign o_ready     = !i_flush && (!buf_valid_r || issue_now_s);
  assign accept_s    = i_submit && o_ready;

  // Next pending counts: issue increments, writeback decrements, both cancel.
  always_comb begin
    underflow_s = 1'b0;
    busy_next_s = 1'b0;
    for (int k = 0; k < REGNO; k++) begin
      pend_next_s[k] = pend_r[k];
      if ((issue_now_s && buf_rf_ie_r[k]) && !(i_wb_valid && i_wb_rf_ie[k])) begin
        pend_next_s[k] = pend_r[k] + {{(PEND_W-1){1'b0}}, 1'b1};
      end else if ((i_wb_valid && i_wb_rf_ie[k]) && !(issue_now_s && buf_rf_ie_r[k])) begin
        if (pend_r[k] != {PEND_W{1'b0}}) begin
          pend_next_s[k] = pend_r[k] - {{(PEND_W-1){1'b0}}, 1'b1};
        end else begin
          underflow_s = 1'b1;
        end
      end else begin
        pend_next_s[k] = pend_r[k];
      end
      busy_next_s = busy_next_s || (pend_next_s[k] != {PEND_W{1'b0}});
    end
  end

  // Pending-write counters and the busy flag derived from them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < REGNO; k++) begin
        pend_r[k] <= {PEND_W{1'b0}};
      end
      o_busy <= 1'b0;
    end else begin
      for (int k = 0; k < REGNO; k++) begin
        pend_r[k] <= pend_next_s[k];
      end
      o_busy <= busy_next_s;
    end
  end

  // Single-entry instruction buffer: flush drops it, accept refills it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buf_valid_r   <= 1'b0;
      buf_l_r       <= {REGNO_LOG{1'b0}};
      buf_r_r       <= {REGNO_LOG{1'b0}};
      buf_used_r    <= 2'b00;
      buf_rf_ie_r   <= {REGNO{1'b0}};
      buf_payload_r <= {PAYLOAD_W{1'b0}};
    end else if (i_flush) begin
      buf_valid_r <= 1'b0;
    end else if (accept_s) begin
      buf_valid_r   <= 1'b1;
      buf_l_r       <= i_l_reg_sel;
      buf_r_r       <= i_r_reg_sel;
      buf_used_r    <= i_used_operands;
      buf_rf_ie_r   <= i_rf_ie;
      buf_payload_r <= i_payload;
    end else if (issue_now_s) begin
      buf_valid_r <= 1'b0;
    end else begin
      buf_valid_r <= buf_valid_r;
    end
  end

  // Registered issue port toward execute; payload/destination hold when idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_submit  <= 1'b0;
      o_payload <= {PAYLOAD_W{1'b0}};
      o_rf_ie   <= {REGNO{1'b0}};
    end else if (issue_now_s) begin
      o_submit  <= 1'b1;
      o_payload <= buf_payload_r;
      o_rf_ie   <= buf_rf_ie_r;
    end else begin
      o_submit  <= 1'b0;
    end
  end

  // Saturating count of cycles a buffered instruction is held by a hazard.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_cycles <= 16'h0000;
    end else if (buf_valid_r && hazard_s && !i_flush && (o_stall_cycles != 16'hFFFF)) begin
      o_stall_cycles <= o_stall_cycles + 16'h0001;
    end else begin
      o_stall_cycles <= o_stall_cycles;
    end
  end

  issue_scoreboard_chk u_chk (
    .clk       (i_clk),
    .rst       (i_rst),
    .underflow (underflow_s)
  );

endmodule

// Protocol checker: a writeback must never target a register with no write
// in flight.
module issue_scoreboard_chk (
  input logic clk,
  input logic rst,
  input logic underflow
);

  // Flag writeback to a register whose pending count is already zero.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!underflow) else $error("issue_scoreboard: writeback with no pending write");
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: independent stream, RAW, WAW saturation,
// issue/writeback collision, backpressure with flush, and async reset.
module tb_issue_scoreboard;

  logic        clk;
  logic        rst;
  logic        submit;
  logic        ready;
  logic [2:0]  l_sel;
  logic [2:0]  r_sel;
  logic [1:0]  used;
  logic [7:0]  rf_ie;
  logic [47:0] payload;
  logic        next_ready;
  logic        o_submit;
  logic [47:0] o_payload;
  logic [7:0]  o_rf_ie;
  logic        wb_valid;
  logic [7:0]  wb_rf_ie;
  logic        flush;
  logic [15:0] stall_cycles;
  logic        busy;

  int checks = 0;
  int errors = 0;

  issue_scoreboard dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_submit        (submit),
    .o_ready         (ready),
    .i_l_reg_sel     (l_sel),
    .i_r_reg_sel     (r_sel),
    .i_used_operands (used),
    .i_rf_ie         (rf_ie),
    .i_payload       (payload),
    .i_next_ready    (next_ready),
    .o_submit        (o_submit),
    .o_payload       (o_payload),
    .o_rf_ie         (o_rf_ie),
    .i_wb_valid      (wb_valid),
    .i_wb_rf_ie      (wb_rf_ie),
    .i_flush         (flush),
    .o_stall_cycles  (stall_cycles),
    .o_busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic [2:0] l, input logic [2:0] r,
                       input logic [1:0] u, input logic [7:0] ie, input logic [47:0] p);
    submit  = s;
    l_sel   = l;
    r_sel   = r;
    used    = u;
    rf_ie   = ie;
    payload = p;
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    #1;
    check(tag, {63'd0, ready}, {63'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; next_ready = 1'b1; wb_valid = 1'b0; wb_rf_ie = 8'h00;
    drive(1'b0, 3'd0, 3'd0, 2'b00, 8'h00, 48'h0);
    #3;
    check("rst_submit", {63'd0, o_submit}, 64'd0);
    check("rst_payload", {16'd0, o_payload}, 64'd0);
    check("rst_stall", {48'd0, stall_cycles}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Independent stream: r1<-r2,r3 then r4<-r5,r6
    drive(1'b1, 3'd2, 3'd3, 2'b11, 8'h02, 48'hA1);
    chk_ready("ind_ready0", 1'b1);
    tick();
    check("ind_nosub_n1", {63'd0, o_submit}, 64'd0);
    drive(1'b1, 3'd5, 3'd6, 2'b11, 8'h10, 48'hB1);
    chk_ready("ind_ready1", 1'b1);
    tick();
    check("ind_sub_a", {63'd0, o_submit}, 64'd1);
    check("ind_pay_a", {16'd0, o_payload}, 64'hA1);
    check("ind_ie_a", {56'd0, o_rf_ie}, 64'h02);
    submit = 1'b0;
    tick();
    check("ind_sub_b", {63'd0, o_submit}, 64'd1);
    check("ind_pay_b", {16'd0, o_payload}, 64'hB1);
    check("ind_ie_b", {56'd0, o_rf_ie}, 64'h10);
    tick();
    check("ind_sub_idle", {63'd0, o_submit}, 64'd0);
    check("ind_pay_hold", {16'd0, o_payload}, 64'hB1);
    check("ind_stall", {48'd0, stall_cycles}, 64'd0);
    check("ind_busy", {63'd0, busy}, 64'd1);
    wb_valid = 1'b1; wb_rf_ie = 8'h02; tick();
    wb_rf_ie = 8'h10; tick();
    wb_valid = 1'b0; wb_rf_ie = 8'h00; tick();
    check("ind_busy_clr", {63'd0, busy}, 64'd0);

    // RAW on r1: three stall cycles, wb in the third
    drive(1'b1, 3'd0, 3'd0, 2'b00, 8'h02, 48'hC1);
    tick();
    drive(1'b1, 3'd1, 3'd0, 2'b01, 8'h00, 48'hC2);
    chk_ready("raw_accept", 1'b1);
    tick();
    check("raw_sub_w", {63'd0, o_submit}, 64'd1);
    check("raw_pay_w", {16'd0, o_payload}, 64'hC1);
    submit = 1'b0;
    chk_ready("raw_ready_stall", 1'b0);
    tick();
    check("raw_hold1", {63'd0, o_submit}, 64'd0);
    tick();
    check("raw_hold2", {63'd0, o_submit}, 64'd0);
    wb_valid = 1'b1; wb_rf_ie = 8'h02;
    tick();
    wb_valid = 1'b0; wb_rf_ie = 8'h00;
    check("raw_hold3_nobypass", {63'd0, o_submit}, 64'd0);
    tick();
    check("raw_sub_r", {63'd0, o_submit}, 64'd1);
    check("raw_pay_r", {16'd0, o_payload}, 64'hC2);
    check("raw_ie_r", {56'd0, o_rf_ie}, 64'h00);
    check("raw_stall", {48'd0, stall_cycles}, 64'd3);

    // WAW saturation on r2
    drive(1'b1, 3'd0, 3'd0, 2'b00, 8'h04, 48'hD1);
    tick();
    payload = 48'hD2; tick();
    check("waw_pay1", {16'd0, o_payload}, 64'hD1);
    payload = 48'hD3; tick();
    check("waw_pay2", {16'd0, o_payload}, 64'hD2);
    payload = 48'hD4; tick();
    check("waw_pay3", {16'd0, o_payload}, 64'hD3);
    submit = 1'b0;
    chk_ready("waw_ready_sat", 1'b0);
    tick();
    check("waw_hold1", {63'd0, o_submit}, 64'd0);
    wb_valid = 1'b1; wb_rf_ie = 8'h04;
    tick();
    wb_valid = 1'b0; wb_rf_ie = 8'h00;
    check("waw_hold2", {63'd0, o_submit}, 64'd0);
    tick();
    check("waw_sub4", {63'd0, o_submit}, 64'd1);
    check("waw_pay4", {16'd0, o_payload}, 64'hD4);
    check("waw_stall", {48'd0, stall_cycles}, 64'd5);
    drive(1'b1, 3'd0, 3'd0, 2'b00, 8'h04, 48'hD5);
    chk_ready("waw_ready5", 1'b1);
    tick();
    submit = 1'b0;
    chk_ready("waw_pend3_again", 1'b0);
    tick();
    check("waw_hold5", {63'd0, o_submit}, 64'd0);
    flush = 1'b1;
    chk_ready("waw_ready_flush", 1'b0);
    tick();
    flush = 1'b0;
    check("waw_flush_nosub", {63'd0, o_submit}, 64'd0);
    check("waw_stall_flush", {48'd0, stall_cycles}, 64'd6);
    wb_valid = 1'b1; wb_rf_ie = 8'h04;
    tick(); tick(); tick();
    wb_valid = 1'b0; wb_rf_ie = 8'h00;
    tick();
    check("waw_busy_clr", {63'd0, busy}, 64'd0);

    // Issue and writeback of r5 in the same cycle; unused operands never stall
    drive(1'b1, 3'd0, 3'd0, 2'b00, 8'h20, 48'hE1);
    tick();
    submit = 1'b0;
    tick();
    check("col_sub_x", {63'd0, o_submit}, 64'd1);
    drive(1'b1, 3'd0, 3'd0, 2'b00, 8'h20, 48'hE2);
    tick();
    drive(1'b1, 3'd5, 3'd5, 2'b00, 8'h00, 48'hE3);
    wb_valid = 1'b1; wb_rf_ie = 8'h20;
    chk_ready("col_ready", 1'b1);
    tick();
    wb_valid = 1'b0; wb_rf_ie = 8'h00;
    check("col_pay_y", {16'd0, o_payload}, 64'hE2);
    drive(1'b1, 3'd5, 3'd0, 2'b01, 8'h00, 48'hE4);
    chk_ready("col_unused_ready", 1'b1);
    tick();
    check("col_sub_z", {63'd0, o_submit}, 64'd1);
    check("col_pay_z", {16'd0, o_payload}, 64'hE3);
    submit = 1'b0;
    chk_ready("col_pend5_one", 1'b0);
    wb_valid = 1'b1; wb_rf_ie = 8'h20;
    tick();
    wb_valid = 1'b0; wb_rf_ie = 8'h00;
    check("col_hold", {63'd0, o_submit}, 64'd0);
    tick();
    check("col_pay_z2", {16'd0, o_payload}, 64'hE4);
    check("col_stall", {48'd0, stall_cycles}, 64'd7);
    tick();
    check("col_busy_clr", {63'd0, busy}, 64'd0);

    // Backpressure for four cycles, then flush
    next_ready = 1'b0;
    drive(1'b1, 3'd0, 3'd0, 2'b00, 8'h40, 48'hF1);
    tick();
    submit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_ready("bp_ready", 1'b0);
      tick();
      check("bp_nosub", {63'd0, o_submit}, 64'd0);
    end
    flush = 1'b1; next_ready = 1'b1;
    drive(1'b1, 3'd0, 3'd0, 2'b00, 8'h00, 48'hF2);
    chk_ready("fl_ready_flush", 1'b0);
    tick();
    flush = 1'b0; submit = 1'b0;
    chk_ready("fl_ready_after", 1'b1);
    check("fl_nosub", {63'd0, o_submit}, 64'd0);
    tick();
    check("fl_empty", {63'd0, o_submit}, 64'd0);
    check("fl_pay_hold", {16'd0, o_payload}, 64'hE4);
    check("fl_stall", {48'd0, stall_cycles}, 64'd7);
    check("fl_busy", {63'd0, busy}, 64'd0);

    // Async reset with pend[3]=2 and a stalled instruction buffered
    drive(1'b1, 3'd0, 3'd0, 2'b00, 8'h08, 48'h71);
    tick();
    payload = 48'h72;
    tick();
    drive(1'b1, 3'd3, 3'd0, 2'b01, 8'h00, 48'h73);
    tick();
    check("ar_sub_pre", {63'd0, o_submit}, 64'd1);
    check("ar_busy_pre", {63'd0, busy}, 64'd1);
    submit = 1'b0;
    chk_ready("ar_ready_stall", 1'b0);
    #2 rst = 1'b1;
    #1;
    check("ar_sub", {63'd0, o_submit}, 64'd0);
    check("ar_pay", {16'd0, o_payload}, 64'd0);
    check("ar_ie", {56'd0, o_rf_ie}, 64'd0);
    check("ar_stall", {48'd0, stall_cycles}, 64'd0);
    check("ar_busy", {63'd0, busy}, 64'd0);
    check("ar_ready", {63'd0, ready}, 64'd1);
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);
    drive(1'b1, 3'd3, 3'd3, 2'b11, 8'h00, 48'h74);
    chk_ready("ar_post_ready", 1'b1);
    tick();
    submit = 1'b0;
    chk_ready("ar_post_issue", 1'b1);
    tick();
    check("ar_post_sub", {63'd0, o_submit}, 64'd1);
    check("ar_post_pay", {16'd0, o_payload}, 64'h74);
    check("ar_post_stall", {48'd0, stall_cycles}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
